branch_ctrl: RTL and testbench
==============================

BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 Parameter: DW, default 8, data width of the channel in bits.
REQ-002 Parameter: CW, default 16, width of each transfer counter.
REQ-003 CLK  input  1  single clock; all state changes on its rising edge.
REQ-004 MR_n  input  1  master reset, synchronous, active-low.
REQ-005 Send_in  input  1  upstream request (4-phase, return-to-zero).
REQ-006 Ack_out  output  1  acknowledge to upstream.
REQ-007 Data_in  input  DW  upstream data, valid while Send_in=1.
REQ-008 Sel_in  input  1  route select: 0 routes to channel a, 1 routes to channel b; valid while Send_in=1.
REQ-009 Send_out_a / Send_out_b  output  1 each  downstream requests.
REQ-010 Ack_in_a / Ack_in_b  input  1 each  downstream acknowledges.
REQ-011 Data_out_a / Data_out_b  output  DW each  slot contents, stable while the matching Send_out is 1.
REQ-012 AEB  output  1  both slots empty and input FSM in IDLE.
REQ-013 Cnt_a / Cnt_b  output  CW each  completed-transfer counters (see Configuration).

Function
REQ-014 Input FSM states: IDLE, ACK, REL.
REQ-015 IDLE->ACK when Send_in=1 and the slot chosen by Sel_in is EMPTY; on that edge, load Data_in into the slot and set the slot to FULL.
REQ-016 Ack_out shall be 1 exactly in ACK and REL; latency from sampled Send_in=1 to Ack_out=1 is one cycle.
REQ-017 ACK->REL unconditionally after one cycle; REL->IDLE when Send_in=0 is sampled; Ack_out falls on that edge.
REQ-018 While in IDLE with Send_in=1 and the target slot not EMPTY, the block shall hold off; Ack_out stays 0 and no data is captured.
REQ-019 Each slot FSM has states EMPTY, FULL and RTZ; Send_out_x = 1 exactly in FULL.
REQ-020 Slot transitions: FULL->RTZ on sampled Ack_in_x=1; RTZ->EMPTY on sampled Ack_in_x=0.
REQ-021 Data_out_x holds the last loaded value and changes only on a load.
REQ-022 The slots are independent: a stalled slot shall not block transfers to the other slot.
REQ-023 There is no bypass: a slot that becomes EMPTY on edge n is eligible for capture at edge n+1, giving a one-cycle bubble.
REQ-024 Sel_in is sampled only at the IDLE->ACK edge; Sel_in changes at any other time have no effect.
REQ-025 AEB is registered: AEB=1 when both slots are EMPTY and the input FSM is in IDLE, otherwise 0.

Reset
REQ-026 While MR_n=0 at a clock edge: input FSM=IDLE, both slots=EMPTY, Ack_out=0, Send_out_a=Send_out_b=0, Data_out_a=Data_out_b=0, Cnt_a=Cnt_b=0, AEB=1.
REQ-027 Reset in the middle of a handshake shall abandon it; captured data is discarded, and after MR_n returns to 1 a still-high Send_in is treated as a new request.

Configuration
REQ-028 With BRANCH_CTRL_CNT_EN defined, Cnt_x increments by 1 on every FULL->RTZ transition of slot x and wraps from 2^CW-1 to 0.
REQ-029 Without BRANCH_CTRL_CNT_EN, Cnt_a and Cnt_b remain as ports, are tied to 0, and no counter flops are synthesized.

Structure
REQ-030 The shared package ddp_hs_pkg shall hold the input-FSM and slot-FSM state typedefs and the default DW/CW constants.
REQ-031 The output slot (state, data register, counter) shall be a sub-module, branch_slot, instantiated twice in branch_ctrl.

Verification
REQ-032 Reset then idle -> all outputs 0 except AEB=1; no Send_out activity for 10 cycles.
REQ-033 Send_in=1, Sel_in=0, Data_in=0x5A -> Ack_out=1 one cycle later; Send_out_a=1 with Data_out_a=0x5A; Send_out_b stays 0; after the Ack_in_a 1->0 cycle, AEB=1 and Cnt_a=1 (with the macro).
REQ-034 Hold Ack_in_a=0 with slot a FULL, then send 0x11 to a -> Ack_out stays 0; then send 0x22 to b -> accepted, Send_out_b=1, Data_out_b=0x22.
REQ-035 Free slot a and present a new request to a on the same cycle -> capture occurs exactly one cycle after the slot reaches EMPTY, with no data corruption.
REQ-036 Assert MR_n=0 during REL with slot b FULL -> next cycle all outputs are at their reset values; release reset with Send_in=1 -> a fresh capture occurs.
REQ-037 CW=4, 17 transfers to channel b with the macro -> Cnt_b=1 (wrapped); same run without the macro -> Cnt_b=0 throughout.

Source files
------------

// File: rtl/ddp_hs_pkg.sv
// Shared definitions for the 4-phase branch controller: default widths and
// the encodings of the input-side and slot-side state machines.
package ddp_hs_pkg;

  localparam int DW_DEFAULT = 8;
  localparam int CW_DEFAULT = 16;

  // Input (upstream) handshake FSM
  typedef logic [1:0] in_state_t;
  localparam in_state_t IN_IDLE = 2'd0;
  localparam in_state_t IN_ACK  = 2'd1;
  localparam in_state_t IN_REL  = 2'd2;

  // Output slot FSM
  typedef logic [1:0] slot_state_t;
  localparam slot_state_t SLOT_EMPTY = 2'd0;
  localparam slot_state_t SLOT_FULL  = 2'd1;
  localparam slot_state_t SLOT_RTZ   = 2'd2;

endpackage

// File: rtl/branch_ctrl_slot.sv
// branch_slot: one downstream output slot of the branch controller.
// Holds the slot FSM (EMPTY/FULL/RTZ), the data register and, when the
// BRANCH_CTRL_CNT_EN macro is defined, a wrapping completed-transfer counter.
// Without the macro the counter output is tied to zero and has no flops.
module branch_slot
  import ddp_hs_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int CW = CW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [DW-1:0] load_data,
  input  logic          ack_in,
  output logic          send_out,
  output logic [DW-1:0] data_out,
  output logic [CW-1:0] cnt,
  output logic          empty,
  output logic          empty_next
);

  slot_state_t   state_reg;
  slot_state_t   state_next;
  logic [DW-1:0] data_reg;
  logic          load_ok;

  // A load is only honoured while the slot is empty; the top guarantees this,
  // the guard keeps a full slot's data stable regardless.
  assign load_ok = load && (state_reg == SLOT_EMPTY);

  // Slot FSM next-state: fill on load, return-to-zero handshake downstream
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      SLOT_EMPTY: if (load_ok) state_next = SLOT_FULL;
      SLOT_FULL:  if (ack_in)  state_next = SLOT_RTZ;
      SLOT_RTZ:   if (!ack_in) state_next = SLOT_EMPTY;
      default:    state_next = SLOT_EMPTY;
    endcase
  end

  // State and data registers; data changes only on a load
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= SLOT_EMPTY;
      data_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (load_ok) data_reg <= load_data;
    end
  end

`ifdef BRANCH_CTRL_CNT_EN
  logic [CW-1:0] cnt_reg;

  // Count each FULL->RTZ transition; natural wrap at 2^CW
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if ((state_reg == SLOT_FULL) && ack_in) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign cnt = cnt_reg;
`else
  assign cnt = '0;
`endif

  assign send_out   = (state_reg == SLOT_FULL);
  assign data_out   = data_reg;
  assign empty      = (state_reg == SLOT_EMPTY);
  assign empty_next = (state_next == SLOT_EMPTY);

endmodule

// File: rtl/branch_ctrl.sv
// branch_ctrl: 4-phase (return-to-zero) handshake demultiplexer.
// One upstream channel is routed by Sel_in into one of two independent
// output slots (a/b). Optional per-slot transfer counters are enabled by
// defining the BRANCH_CTRL_CNT_EN macro.
module branch_ctrl
  import ddp_hs_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int CW = CW_DEFAULT
) (
  input  logic          CLK,
  input  logic          MR_n,
  input  logic          Send_in,
  output logic          Ack_out,
  input  logic [DW-1:0] Data_in,
  input  logic          Sel_in,
  output logic          Send_out_a,
  output logic          Send_out_b,
  input  logic          Ack_in_a,
  input  logic          Ack_in_b,
  output logic [DW-1:0] Data_out_a,
  output logic [DW-1:0] Data_out_b,
  output logic          AEB,
  output logic [CW-1:0] Cnt_a,
  output logic [CW-1:0] Cnt_b
);

  in_state_t in_state_reg;
  in_state_t in_state_next;
  logic      aeb_reg;

  logic      empty_a;
  logic      empty_b;
  logic      empty_next_a;
  logic      empty_next_b;
  logic      target_empty;
  logic      capture;
  logic      load_a;
  logic      load_b;

  // Sel_in only matters here, on the IDLE->ACK edge. Slot emptiness is the
  // registered state, so a slot freed on one edge is usable on the next.
  assign target_empty = Sel_in ? empty_b : empty_a;
  assign capture      = (in_state_reg == IN_IDLE) && Send_in && target_empty;
  assign load_a       = capture && !Sel_in;
  assign load_b       = capture && Sel_in;

  // Input FSM next-state: accept, acknowledge, wait for upstream release
  always_comb begin
    in_state_next = in_state_reg;
    case (in_state_reg)
      IN_IDLE: if (capture)  in_state_next = IN_ACK;
      IN_ACK:                in_state_next = IN_REL;
      IN_REL:  if (!Send_in) in_state_next = IN_IDLE;
      default:               in_state_next = IN_IDLE;
    endcase
  end

  // Input FSM state and AEB flag; AEB is built from next-state values so the
  // registered flag lines up with the states it describes
  always_ff @(posedge CLK) begin
    if (!MR_n) begin
      in_state_reg <= IN_IDLE;
      aeb_reg      <= 1'b1;
    end else begin
      in_state_reg <= in_state_next;
      aeb_reg      <= (in_state_next == IN_IDLE) && empty_next_a && empty_next_b;
    end
  end

  assign Ack_out = (in_state_reg == IN_ACK) || (in_state_reg == IN_REL);
  assign AEB     = aeb_reg;

  branch_slot #(
    .DW (DW),
    .CW (CW)
  ) u_slot_a (
    .clk        (CLK),
    .rst_n      (MR_n),
    .load       (load_a),
    .load_data  (Data_in),
    .ack_in     (Ack_in_a),
    .send_out   (Send_out_a),
    .data_out   (Data_out_a),
    .cnt        (Cnt_a),
    .empty      (empty_a),
    .empty_next (empty_next_a)
  );

  branch_slot #(
    .DW (DW),
    .CW (CW)
  ) u_slot_b (
    .clk        (CLK),
    .rst_n      (MR_n),
    .load       (load_b),
    .load_data  (Data_in),
    .ack_in     (Ack_in_b),
    .send_out   (Send_out_b),
    .data_out   (Data_out_b),
    .cnt        (Cnt_b),
    .empty      (empty_b),
    .empty_next (empty_next_b)
  );

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed testbench for branch_ctrl (DW=8, CW=4). Expected counter values
// depend on whether BRANCH_CTRL_CNT_EN is defined for the build.
module tb_branch_ctrl;

  localparam int DW = 8;
  localparam int CW = 4;

  logic          CLK;
  logic          MR_n;
  logic          Send_in;
  logic          Ack_out;
  logic [DW-1:0] Data_in;
  logic          Sel_in;
  logic          Send_out_a;
  logic          Send_out_b;
  logic          Ack_in_a;
  logic          Ack_in_b;
  logic [DW-1:0] Data_out_a;
  logic [DW-1:0] Data_out_b;
  logic          AEB;
  logic [CW-1:0] Cnt_a;
  logic [CW-1:0] Cnt_b;

  int errors = 0;
  int checks = 0;
  int cnt_a_exp = 0;
  int cnt_b_exp = 0;

  branch_ctrl #(
    .DW (DW),
    .CW (CW)
  ) dut (
    .CLK        (CLK),
    .MR_n       (MR_n),
    .Send_in    (Send_in),
    .Ack_out    (Ack_out),
    .Data_in    (Data_in),
    .Sel_in     (Sel_in),
    .Send_out_a (Send_out_a),
    .Send_out_b (Send_out_b),
    .Ack_in_a   (Ack_in_a),
    .Ack_in_b   (Ack_in_b),
    .Data_out_a (Data_out_a),
    .Data_out_b (Data_out_b),
    .AEB        (AEB),
    .Cnt_a      (Cnt_a),
    .Cnt_b      (Cnt_b)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Advance one rising edge and settle just after it
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Counter advances by one per drained transfer only when the feature is built in
  function automatic int cnt_inc(input int c);
`ifdef BRANCH_CTRL_CNT_EN
    return (c + 1) % 16;
`else
    return c;
`endif
  endfunction

  // Full upstream handshake to an empty slot; checks acknowledge timing
  task automatic send(input logic sel, input logic [DW-1:0] data);
    Send_in = 1'b1;
    Sel_in  = sel;
    Data_in = data;
    step();
    check("send_ack_rise", 32'(Ack_out), 1);
    Send_in = 1'b0;
    Sel_in  = ~sel;
    Data_in = 8'hEE;
    step();
    check("send_ack_rel", 32'(Ack_out), 1);
    step();
    check("send_ack_fall", 32'(Ack_out), 0);
  endtask

  // Downstream 4-phase acknowledge on channel a (sel=0) or b (sel=1)
  task automatic drain(input logic sel);
    if (sel) Ack_in_b = 1'b1; else Ack_in_a = 1'b1;
    step();
    if (sel) begin
      cnt_b_exp = cnt_inc(cnt_b_exp);
      check("drain_b_send_low", 32'(Send_out_b), 0);
      check("drain_b_cnt", 32'(Cnt_b), cnt_b_exp);
      Ack_in_b = 1'b0;
    end else begin
      cnt_a_exp = cnt_inc(cnt_a_exp);
      check("drain_a_send_low", 32'(Send_out_a), 0);
      check("drain_a_cnt", 32'(Cnt_a), cnt_a_exp);
      Ack_in_a = 1'b0;
    end
    step();
  endtask

  initial begin
    MR_n     = 1'b0;
    Send_in  = 1'b0;
    Data_in  = '0;
    Sel_in   = 1'b0;
    Ack_in_a = 1'b0;
    Ack_in_b = 1'b0;

    // Reset then idle
    step();
    step();
    check("rst_ack", 32'(Ack_out), 0);
    check("rst_send_a", 32'(Send_out_a), 0);
    check("rst_send_b", 32'(Send_out_b), 0);
    check("rst_data_a", 32'(Data_out_a), 0);
    check("rst_data_b", 32'(Data_out_b), 0);
    check("rst_cnt_a", 32'(Cnt_a), 0);
    check("rst_cnt_b", 32'(Cnt_b), 0);
    check("rst_aeb", 32'(AEB), 1);
    MR_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("idle_send", 32'({Send_out_a, Send_out_b, Ack_out}), 0);
      check("idle_aeb", 32'(AEB), 1);
    end

    // Basic transfer of 0x5A to channel a
    Send_in = 1'b1;
    Sel_in  = 1'b0;
    Data_in = 8'h5A;
    step();
    check("t1_ack", 32'(Ack_out), 1);
    check("t1_send_a", 32'(Send_out_a), 1);
    check("t1_data_a", 32'(Data_out_a), 8'h5A);
    check("t1_send_b", 32'(Send_out_b), 0);
    check("t1_aeb", 32'(AEB), 0);
    Send_in = 1'b0;
    Sel_in  = 1'b1;
    step();
    check("t1_ack_rel", 32'(Ack_out), 1);
    step();
    check("t1_ack_fall", 32'(Ack_out), 0);
    check("t1_send_b_still", 32'(Send_out_b), 0);
    check("t1_aeb_slot_full", 32'(AEB), 0);
    drain(1'b0);
    check("t1_aeb_done", 32'(AEB), 1);
    check("t1_data_hold", 32'(Data_out_a), 8'h5A);

    // Slot a stalled: requests to a are held off, b still flows
    send(1'b0, 8'h33);
    check("t2_a_full", 32'(Send_out_a), 1);
    Send_in = 1'b1;
    Sel_in  = 1'b0;
    Data_in = 8'h11;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t2_holdoff_ack", 32'(Ack_out), 0);
      check("t2_holdoff_data", 32'(Data_out_a), 8'h33);
    end
    Sel_in  = 1'b1;
    Data_in = 8'h22;
    step();
    check("t2_b_ack", 32'(Ack_out), 1);
    check("t2_b_send", 32'(Send_out_b), 1);
    check("t2_b_data", 32'(Data_out_b), 8'h22);
    check("t2_a_untouched", 32'(Data_out_a), 8'h33);
    // Sel_in change after capture has no effect
    Sel_in  = 1'b0;
    Data_in = 8'h99;
    Send_in = 1'b0;
    step();
    step();
    check("t2_sel_late_b", 32'(Data_out_b), 8'h22);
    check("t2_sel_late_a", 32'(Data_out_a), 8'h33);
    drain(1'b1);

    // Free slot a while a new request for a is waiting: one-cycle bubble
    Ack_in_a = 1'b1;
    step();
    cnt_a_exp = cnt_inc(cnt_a_exp);
    check("t3_a_rtz", 32'(Send_out_a), 0);
    Ack_in_a = 1'b0;
    Send_in  = 1'b1;
    Sel_in   = 1'b0;
    Data_in  = 8'h44;
    step();
    check("t3_bubble_ack", 32'(Ack_out), 0);
    check("t3_bubble_data", 32'(Data_out_a), 8'h33);
    step();
    check("t3_cap_ack", 32'(Ack_out), 1);
    check("t3_cap_send", 32'(Send_out_a), 1);
    check("t3_cap_data", 32'(Data_out_a), 8'h44);
    check("t3_cnt_a", 32'(Cnt_a), cnt_a_exp);
    Send_in = 1'b0;
    step();
    step();
    drain(1'b0);
    check("t3_aeb", 32'(AEB), 1);

    // Reset during REL with slot b full
    Send_in = 1'b1;
    Sel_in  = 1'b1;
    Data_in = 8'h66;
    step();
    step();
    check("t4_in_rel", 32'(Ack_out), 1);
    check("t4_b_full", 32'(Send_out_b), 1);
    MR_n    = 1'b0;
    Data_in = 8'h77;
    step();
    cnt_a_exp = 0;
    cnt_b_exp = 0;
    check("t4_rst_ack", 32'(Ack_out), 0);
    check("t4_rst_send_b", 32'(Send_out_b), 0);
    check("t4_rst_data_a", 32'(Data_out_a), 0);
    check("t4_rst_data_b", 32'(Data_out_b), 0);
    check("t4_rst_cnt_a", 32'(Cnt_a), 0);
    check("t4_rst_cnt_b", 32'(Cnt_b), 0);
    check("t4_rst_aeb", 32'(AEB), 1);
    MR_n = 1'b1;
    step();
    check("t4_fresh_ack", 32'(Ack_out), 1);
    check("t4_fresh_send", 32'(Send_out_b), 1);
    check("t4_fresh_data", 32'(Data_out_b), 8'h77);
    Send_in = 1'b0;
    step();
    step();
    drain(1'b1);

    // 16 more transfers to b: 17 in total since reset, wraps a 4-bit counter to 1
    for (int i = 0; i < 16; i++) begin
      send(1'b1, 8'(8'hA0 + i));
      check("t5_data_b", 32'(Data_out_b), 8'hA0 + i);
      drain(1'b1);
    end
`ifdef BRANCH_CTRL_CNT_EN
    check("t5_cnt_b_wrap", 32'(Cnt_b), 1);
`else
    check("t5_cnt_b_off", 32'(Cnt_b), 0);
`endif
    check("t5_cnt_a", 32'(Cnt_a), 0);
    check("t5_aeb", 32'(AEB), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
